// File: rtl/einstein_io_pkg.sv
// Shared types and widths for the Einstein I/O bus cycle initiator.
package einstein_io_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    OP_RD   = 2'b00,
    OP_WR   = 2'b01,
    OP_INTA = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4,
    DONE = 3'd5
  } state_e;

endpackage

// File: rtl/einstein_io_master_if.sv
// Agent request/response handshake plus the Z80-style I/O bus pins.
interface einstein_io_master_if;
  import einstein_io_pkg::*;

  logic              req;
  op_e               req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] DO;
  logic              DOE;
  logic [DATA_W-1:0] DI;
  logic              IORQ_n;
  logic              RD_n;
  logic              WR_n;
  logic              M1_n;
  logic              WAIT_n;

  modport master (
    input  req, req_op, req_addr, req_wdata, DI, WAIT_n,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output A, DO, DOE, IORQ_n, RD_n, WR_n, M1_n
  );

  modport slave (
    output req, req_op, req_addr, req_wdata, DI, WAIT_n,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  A, DO, DOE, IORQ_n, RD_n, WR_n, M1_n
  );

endinterface

// File: rtl/einstein_io_master.sv
// Issues single I/O read, I/O write and INTA cycles with CPU-identical
// T1/T2/TW/T3 strobe timing on behalf of an internal bus agent.
module einstein_io_master
  import einstein_io_pkg::*;
#(
  parameter int unsigned AUTO_WAIT    = 1,
  parameter int unsigned INTA_WAIT    = 2,
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ce,
  einstein_io_master_if.master bus
);

  state_e           state;
  op_e              op_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] ext_cnt;
  logic             err_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      op_q          <= OP_RD;
      wait_cnt      <= '0;
      ext_cnt       <= '0;
      err_q         <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 8'hFF;
      bus.rsp_err   <= 1'b0;
      bus.A         <= '0;
      bus.DO        <= '0;
      bus.DOE       <= 1'b0;
      bus.IORQ_n    <= 1'b1;
      bus.RD_n      <= 1'b1;
      bus.WR_n      <= 1'b1;
      bus.M1_n      <= 1'b1;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req && bus.req_ready) begin
            op_q          <= bus.req_op;
            bus.A         <= bus.req_addr;
            bus.req_ready <= 1'b0;
            err_q         <= 1'b0;
            ext_cnt       <= '0;
            if (bus.req_op == OP_RSV) begin
              // Reserved op never touches the bus; answer with an error at once.
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= 8'hFF;
              state         <= DONE;
            end else begin
              if (bus.req_op == OP_WR) begin
                bus.DO  <= bus.req_wdata;
                bus.DOE <= 1'b1;
              end
              if (bus.req_op == OP_INTA) begin
                bus.M1_n <= 1'b0;
              end
              state <= T1;
            end
          end
        end

        T1: begin
          if (ce) begin
            wait_cnt <= (op_q == OP_INTA) ? CNT_W'(INTA_WAIT) : CNT_W'(AUTO_WAIT);
            if (op_q == OP_RD) begin
              bus.IORQ_n <= 1'b0;
              bus.RD_n   <= 1'b0;
            end
            if (op_q == OP_WR) begin
              bus.IORQ_n <= 1'b0;
              bus.WR_n   <= 1'b0;
            end
            state <= T2;
          end
        end

        T2: begin
          if (ce) begin
            // INTA delays IORQ_n by one T-state so the vector has time to settle.
            if (op_q == OP_INTA) begin
              bus.IORQ_n <= 1'b0;
            end
            state <= TW;
          end
        end

        TW: begin
          if (ce) begin
            if (wait_cnt > CNT_W'(1)) begin
              wait_cnt <= wait_cnt - CNT_W'(1);
            end else if ((WAIT_TIMEOUT != 0) && (ext_cnt == CNT_W'(WAIT_TIMEOUT))) begin
              err_q <= 1'b1;
              state <= T3;
            end else if (!bus.WAIT_n) begin
              ext_cnt <= ext_cnt + CNT_W'(1);
            end else begin
              state <= T3;
            end
          end
        end

        T3: begin
          if (ce) begin
            if (op_q != OP_WR) begin
              bus.rsp_rdata <= err_q ? 8'hFF : bus.DI;
            end
            bus.IORQ_n    <= 1'b1;
            bus.RD_n      <= 1'b1;
            bus.WR_n      <= 1'b1;
            bus.M1_n      <= 1'b1;
            bus.DOE       <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= err_q;
            state         <= DONE;
          end
        end

        DONE: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_einstein_io_master.sv
// Directed scoreboard bench: stimulus pushes expected responses, a monitor pops them.
module tb_einstein_io_master;
  import einstein_io_pkg::*;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic ce      = 1'b0;

  always #5 clk_sys = ~clk_sys;

  einstein_io_master_if b0 ();
  einstein_io_master_if b1 ();

  einstein_io_master #(.AUTO_WAIT(1), .INTA_WAIT(2), .WAIT_TIMEOUT(0)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce      (ce),
    .bus     (b0)
  );

  einstein_io_master #(.AUTO_WAIT(1), .INTA_WAIT(2), .WAIT_TIMEOUT(4)) dut_to (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce      (ce),
    .bus     (b1)
  );

  typedef struct {
    bit         inst;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam int C_IORQ = 0, C_RD = 1, C_WR = 2, C_M1 = 3, C_M1PRE = 4;
  localparam int C_DOE = 5, C_VIOL = 6, C_ANY = 7, C_IORQ1 = 8, C_SEL = 9;
  localparam int NC = 17;
  int         cnt  [NC];
  int         base [NC];
  logic [7:0] exp_do = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bench-side model of the Einstein port decoder (ports 0x00-0x3F in groups of 8).
  function automatic logic [7:0] dec(input logic [15:0] a, input logic iorq_n, input logic m1_n);
    logic [7:0] s;
    s = 8'h00;
    if (!iorq_n && m1_n && a[7:6] == 2'b00) s[a[5:3]] = 1'b1;
    return s;
  endfunction

  function automatic int d(input int i);
    return cnt[i] - base[i];
  endfunction

  function automatic logic [7:0] selmask();
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) if (cnt[C_SEL+i] != base[C_SEL+i]) m[i] = 1'b1;
    return m;
  endfunction

  task automatic snap();
    for (int i = 0; i < NC; i++) base[i] = cnt[i];
  endtask

  initial for (int i = 0; i < NC; i++) cnt[i] = 0;

  // Strobe tracker: duration counts are taken per ce period (sampled before the ce edge).
  always @(negedge clk_sys) begin
    logic [7:0] s;
    if (reset_n) begin
      if (ce) begin
        if (!b0.IORQ_n) cnt[C_IORQ]++;
        if (!b0.RD_n) cnt[C_RD]++;
        if (!b0.WR_n) cnt[C_WR]++;
        if (!b0.M1_n) cnt[C_M1]++;
        if (!b0.M1_n && b0.IORQ_n) cnt[C_M1PRE]++;
        if (b0.DOE && b0.DO == exp_do) cnt[C_DOE]++;
        if (!b1.IORQ_n) cnt[C_IORQ1]++;
      end
      if (!b0.RD_n && !b0.WR_n) cnt[C_VIOL]++;
      if (!b0.WR_n && !b0.DOE) cnt[C_VIOL]++;
      if (!b0.IORQ_n || !b0.RD_n || !b0.WR_n || !b0.M1_n) cnt[C_ANY]++;
      s = dec(b0.A, b0.IORQ_n, b0.M1_n);
      for (int i = 0; i < 8; i++) if (s[i]) cnt[C_SEL+i]++;
    end
  end

  task automatic score(input bit inst, input logic [7:0] rdata, input logic err);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_rsp: inst %0d rdata %0h err %0b with nothing expected", inst, rdata, err);
    end else begin
      e = exp_q.pop_front();
      check("rsp_inst", 32'(inst), 32'(e.inst));
      check("rsp_rdata", 32'(rdata), 32'(e.rdata));
      check("rsp_err", 32'(err), 32'(e.err));
    end
  endtask

  // Response monitor, decoupled from stimulus.
  always @(negedge clk_sys) begin
    if (b0.rsp_valid === 1'b1) score(1'b0, b0.rsp_rdata, b0.rsp_err);
    if (b1.rsp_valid === 1'b1) score(1'b1, b1.rsp_rdata, b1.rsp_err);
  end

  task automatic push(input bit inst, input logic [7:0] rdata, input logic err);
    exp_t e;
    e.inst  = inst;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // One T-state: ce high for the first clock of four.
  task automatic ce_period();
    ce = 1'b1;
    @(posedge clk_sys);
    #1 ce = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
  endtask

  task automatic issue0(input op_e op, input logic [15:0] addr, input logic [7:0] wdata);
    bit ok;
    ok = 1'b0;
    b0.req_op    = op;
    b0.req_addr  = addr;
    b0.req_wdata = wdata;
    b0.req       = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_sys);
      if (b0.req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk_sys);
    #1 b0.req = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk_sys);
    end
    if (exp_q.size() != 0) begin
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk_sys);
    #1;
  endtask

  logic [7:0] last0 = 8'hFF;

  initial begin
    b0.req = 1'b0; b0.req_op = OP_RD; b0.req_addr = '0; b0.req_wdata = '0;
    b0.DI = 8'h00; b0.WAIT_n = 1'b1;
    b1.req = 1'b0; b1.req_op = OP_RD; b1.req_addr = '0; b1.req_wdata = '0;
    b1.DI = 8'h00; b1.WAIT_n = 1'b1;

    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    @(negedge clk_sys);
    check("rst_strobes", 32'({b0.IORQ_n, b0.RD_n, b0.WR_n, b0.M1_n, b0.DOE}), 32'h1E);
    check("rst_A_DO", 32'({b0.A, b0.DO}), 32'h0);
    check("rst_rsp", 32'({b0.rsp_valid, b0.rsp_err, b0.rsp_rdata}), 32'h0FF);
    check("rst_ready", 32'(b0.req_ready), 32'd1);
    @(posedge clk_sys);
    #1;

    // Reset in the middle of an extended write: cycle is dropped silently.
    b0.WAIT_n = 1'b0;
    exp_do    = 8'h11;
    issue0(OP_WR, 16'h0010, 8'h11);
    repeat (3) ce_period();
    check("rst_pre_wr", 32'({b0.WR_n, b0.DOE}), 32'h1);
    #2 reset_n = 1'b0;
    #1 check("rst_mid_strobes", 32'({b0.IORQ_n, b0.RD_n, b0.WR_n, b0.M1_n, b0.DOE}), 32'h1E);
    @(posedge clk_sys);
    #1 reset_n = 1'b1;
    b0.WAIT_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("rst_mid_ready", 32'(b0.req_ready), 32'd1);
    @(posedge clk_sys);
    #1;

    // Read FDC port 0x18, no external waits.
    b0.DI = 8'hA5;
    snap();
    push(1'b0, 8'hA5, 1'b0);
    last0 = 8'hA5;
    issue0(OP_RD, 16'h0018, 8'h00);
    repeat (4) ce_period();
    wait_drain("rd_drain");
    check("rd_iorq_len", 32'(d(C_IORQ)), 32'd3);
    check("rd_rd_len", 32'(d(C_RD)), 32'd3);
    check("rd_sel", 32'(selmask()), 32'h08);
    check("rd_viol", 32'(d(C_VIOL)), 32'd0);

    // Write 0x25 <- 3C with WAIT_n low for five TW samples.
    b0.DI     = 8'h00;
    exp_do    = 8'h3C;
    b0.WAIT_n = 1'b0;
    snap();
    push(1'b0, last0, 1'b0);
    issue0(OP_WR, 16'h0025, 8'h3C);
    repeat (7) ce_period();
    b0.WAIT_n = 1'b1;
    repeat (2) ce_period();
    wait_drain("wr_drain");
    check("wr_wr_len", 32'(d(C_WR)), 32'd8);
    check("wr_iorq_len", 32'(d(C_IORQ)), 32'd8);
    check("wr_doe_len", 32'(d(C_DOE)), 32'd9);
    check("wr_sel", 32'(selmask()), 32'h10);
    check("wr_viol", 32'(d(C_VIOL)), 32'd0);
    check("wr_A_hold", 32'(b0.A), 32'h0025);
    check("wr_DO_hold", 32'({b0.DO, b0.DOE}), 32'h78);

    // INTA: M1_n for the whole cycle, IORQ_n only from TW.
    b0.DI = 8'hE8;
    snap();
    push(1'b0, 8'hE8, 1'b0);
    last0 = 8'hE8;
    issue0(OP_INTA, 16'h0018, 8'h00);
    repeat (5) ce_period();
    wait_drain("inta_drain");
    check("inta_m1_len", 32'(d(C_M1)), 32'd5);
    check("inta_iorq_len", 32'(d(C_IORQ)), 32'd3);
    check("inta_m1_before_iorq", 32'(d(C_M1PRE)), 32'd2);
    check("inta_sel", 32'(selmask()), 32'h00);
    check("inta_rd_wr", 32'(d(C_RD) + d(C_WR)), 32'd0);

    // Back-to-back read then reserved op with req held high.
    b0.DI = 8'h5A;
    push(1'b0, 8'h5A, 1'b0);
    push(1'b0, 8'hFF, 1'b1);
    issue0(OP_RD, 16'h0018, 8'h00);
    b0.req    = 1'b1;
    b0.req_op = OP_RSV;
    repeat (3) ce_period();
    ce = 1'b1;
    @(posedge clk_sys);
    #1 ce = 1'b0;
    @(negedge clk_sys);
    check("b2b_rd_done", 32'(b0.rsp_valid), 32'd1);
    @(negedge clk_sys);
    check("b2b_ready_after_done", 32'(b0.req_ready), 32'd1);
    @(posedge clk_sys);
    #1 b0.req = 1'b0;
    snap();
    @(negedge clk_sys);
    check("rsv_done_next_clk", 32'({b0.rsp_valid, b0.req_ready}), 32'h2);
    @(negedge clk_sys);
    check("rsv_idle", 32'({b0.rsp_valid, b0.req_ready}), 32'h1);
    check("rsv_no_strobe", 32'(d(C_ANY)), 32'd0);
    wait_drain("b2b_drain");

    // Timeout instance: WAIT_n stuck low on a read.
    b1.DI     = 8'h77;
    b1.WAIT_n = 1'b0;
    snap();
    push(1'b1, 8'hFF, 1'b1);
    b1.req_op   = OP_RD;
    b1.req_addr = 16'h0018;
    b1.req      = 1'b1;
    @(posedge clk_sys);
    #1 b1.req = 1'b0;
    repeat (8) ce_period();
    wait_drain("to_drain");
    check("to_iorq_len", 32'(d(C_IORQ1)), 32'd7);
    check("to_strobes_idle", 32'({b1.IORQ_n, b1.RD_n, b1.req_ready}), 32'h7);
    b1.WAIT_n = 1'b1;

    repeat (4) @(posedge clk_sys);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
